// File: rtl/shunt_hs_rtl_pkg.sv
// Shared types and constants for the SHUNT handshake segment transmitter.
// SHUNT_HS_SEG_CHECKSUM_EN adds the CSUM state used for the per-segment XOR beat.
package shunt_hs_rtl_pkg;

    localparam int HS_HDR_BEATS = 4;
    localparam int HDR_FIELD_W  = 64;

    localparam logic [1:0] HDR_IDX_TYPE  = 2'd0;
    localparam logic [1:0] HDR_IDX_ID    = 2'd1;
    localparam logic [1:0] HDR_IDX_DTYPE = 2'd2;
    localparam logic [1:0] HDR_IDX_NPAY  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
`ifdef SHUNT_HS_SEG_CHECKSUM_EN
        ,
        CSUM = 2'd3
`endif
    } hs_tx_state_e;

    typedef struct packed {
        logic [HDR_FIELD_W-1:0] trnx_type;
        logic [HDR_FIELD_W-1:0] trnx_id;
        logic [HDR_FIELD_W-1:0] data_type;
        logic [HDR_FIELD_W-1:0] n_payloads;
    } hs_hdr_t;

    function automatic logic [HDR_FIELD_W-1:0] hdr_field(input hs_hdr_t hdr, input logic [1:0] idx);
        case (idx)
            HDR_IDX_TYPE:  return hdr.trnx_type;
            HDR_IDX_ID:    return hdr.trnx_id;
            HDR_IDX_DTYPE: return hdr.data_type;
            HDR_IDX_NPAY:  return hdr.n_payloads;
            default:       return '0;
        endcase
    endfunction

endpackage

// File: rtl/shunt_hs_out_reg.sv
// Single valid/ready output register: accepts a new beat whenever empty or draining,
// holds data/sof/last/fin stable while stalled.
module shunt_hs_out_reg #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_sof,
    input  logic              push_last,
    input  logic              push_fin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sof,
    output logic              out_last,
    output logic              out_fin
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              sof_q, sof_d;
    logic              last_q, last_d;
    logic              fin_q, fin_d;

    assign push_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sof_d   = sof_q;
        last_d  = last_q;
        fin_d   = fin_q;
        if (push_valid && push_ready) begin
            valid_d = 1'b1;
            data_d  = push_data;
            sof_d   = push_sof;
            last_d  = push_last;
            fin_d   = push_fin;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sof_q   <= 1'b0;
            last_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sof_q   <= sof_d;
            last_q  <= last_d;
            fin_q   <= fin_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sof   = sof_q & valid_q;
    assign out_last  = last_q & valid_q;
    assign out_fin   = fin_q & valid_q;

endmodule

// File: rtl/shunt_hs_seg_tx.sv
// SHUNT handshake transmit framer: per segment a 4-beat header then the payload beats.
// Define SHUNT_HS_SEG_CHECKSUM_EN to append a per-segment XOR checksum beat.
module shunt_hs_seg_tx
    import shunt_hs_rtl_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int MAX_SEG = 8,
    parameter int SIZE_W  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [63:0]                   cmd_trnx_type,
    input  logic [63:0]                   cmd_trnx_id,
    input  logic [63:0]                   cmd_data_type,
    input  logic [$clog2(MAX_SEG+1)-1:0]  cmd_n_seg,
    input  logic [MAX_SEG*SIZE_W-1:0]     cmd_seg_sizes,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_sof,
    output logic                          out_last,
    output logic                          done,
    output logic                          busy
);

    localparam int NSEG_W    = $clog2(MAX_SEG + 1);
    localparam int SEG_IDX_W = (MAX_SEG > 1) ? $clog2(MAX_SEG) : 1;

    hs_tx_state_e         state_q, state_d;
    logic [SEG_IDX_W-1:0] seg_idx_q, seg_idx_d;
    logic [1:0]           hdr_beat_q, hdr_beat_d;
    logic [SIZE_W-1:0]    pay_cnt_q, pay_cnt_d;
    logic [63:0]          type_q, type_d;
    logic [63:0]          id_q, id_d;
    logic [63:0]          dtype_q, dtype_d;
    logic [NSEG_W-1:0]    n_seg_q, n_seg_d;
    logic                 zero_done_q, zero_done_d;
    logic                 run_q;
`ifdef SHUNT_HS_SEG_CHECKSUM_EN
    logic [DATA_W-1:0]    csum_q, csum_d;
`endif

    logic [SIZE_W-1:0] cmd_size [MAX_SEG];
    logic [SIZE_W-1:0] seg_size_q [MAX_SEG];
    logic [SIZE_W-1:0] seg_size_d [MAX_SEG];

    logic              cmd_load;
    logic [NSEG_W-1:0] n_seg_clamp;
    logic [SIZE_W-1:0] cur_size;
    logic              seg_is_last;
    hs_hdr_t           cur_hdr;
    logic              end_seg;

    logic              push_valid, push_ready;
    logic [DATA_W-1:0] push_data;
    logic              push_sof, push_last, push_fin;
    logic              out_fin;

    // Segment size table: unpacked from the command bus and latched per entry.
    generate
        for (genvar gi = 0; gi < MAX_SEG; gi++) begin : g_seg
            assign cmd_size[gi] = cmd_seg_sizes[gi*SIZE_W +: SIZE_W];

            always_comb begin
                seg_size_d[gi] = cmd_load ? cmd_size[gi] : seg_size_q[gi];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    seg_size_q[gi] <= '0;
                end else begin
                    seg_size_q[gi] <= seg_size_d[gi];
                end
            end
        end
    endgenerate

    // Command is only taken once the previous final beat has drained.
    assign cmd_ready   = run_q && (state_q == IDLE) && !out_valid;
    assign cmd_load    = cmd_valid && cmd_ready;
    assign n_seg_clamp = (cmd_n_seg > NSEG_W'(MAX_SEG)) ? NSEG_W'(MAX_SEG) : cmd_n_seg;
    assign cur_size    = seg_size_q[seg_idx_q];
    assign seg_is_last = (NSEG_W'(seg_idx_q) + NSEG_W'(1)) == n_seg_q;

    always_comb begin
        cur_hdr.trnx_type  = type_q;
        cur_hdr.trnx_id    = id_q;
        cur_hdr.data_type  = dtype_q;
        cur_hdr.n_payloads = 64'(cur_size);
    end

    always_comb begin
        state_d     = state_q;
        seg_idx_d   = seg_idx_q;
        hdr_beat_d  = hdr_beat_q;
        pay_cnt_d   = pay_cnt_q;
        type_d      = type_q;
        id_d        = id_q;
        dtype_d     = dtype_q;
        n_seg_d     = n_seg_q;
        zero_done_d = 1'b0;
`ifdef SHUNT_HS_SEG_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        push_valid  = 1'b0;
        push_data   = '0;
        push_sof    = 1'b0;
        push_last   = 1'b0;
        push_fin    = 1'b0;
        in_ready    = 1'b0;
        end_seg     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_load) begin
                    type_d  = cmd_trnx_type;
                    id_d    = cmd_trnx_id;
                    dtype_d = cmd_data_type;
                    n_seg_d = n_seg_clamp;
                    if (n_seg_clamp == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        // Header beat 0 goes straight into the empty output register.
                        push_valid = 1'b1;
                        push_sof   = 1'b1;
                        push_data  = DATA_W'(cmd_trnx_type);
                        seg_idx_d  = '0;
                        hdr_beat_d = HDR_IDX_ID;
                        state_d    = HDR;
                    end
                end
            end
            HDR: begin
                push_valid = 1'b1;
                push_sof   = (hdr_beat_q == HDR_IDX_TYPE);
                push_data  = DATA_W'(hdr_field(cur_hdr, hdr_beat_q));
                if (push_ready) begin
                    if (hdr_beat_q == 2'(HS_HDR_BEATS - 1)) begin
                        pay_cnt_d = '0;
`ifdef SHUNT_HS_SEG_CHECKSUM_EN
                        csum_d    = '0;
                        state_d   = (cur_size != '0) ? PAY : CSUM;
`else
                        if (cur_size != '0) begin
                            state_d = PAY;
                        end else begin
                            end_seg = 1'b1;
                        end
`endif
                    end else begin
                        hdr_beat_d = hdr_beat_q + 2'd1;
                    end
                end
            end
            PAY: begin
                in_ready   = push_ready;
                push_valid = in_valid;
                push_data  = in_data;
                if (in_valid && push_ready) begin
`ifdef SHUNT_HS_SEG_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                    if (pay_cnt_q == cur_size - 1'b1) begin
`ifdef SHUNT_HS_SEG_CHECKSUM_EN
                        state_d = CSUM;
`else
                        end_seg = 1'b1;
`endif
                    end else begin
                        pay_cnt_d = pay_cnt_q + 1'b1;
                    end
                end
            end
`ifdef SHUNT_HS_SEG_CHECKSUM_EN
            CSUM: begin
                push_valid = 1'b1;
                push_data  = csum_q;
                end_seg    = push_ready;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Closing beat of a segment: mark last, then next segment or finish.
        if (end_seg) begin
            push_last = 1'b1;
            if (seg_is_last) begin
                push_fin = 1'b1;
                state_d  = IDLE;
            end else begin
                seg_idx_d  = seg_idx_q + 1'b1;
                hdr_beat_d = HDR_IDX_TYPE;
                state_d    = HDR;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            seg_idx_q   <= '0;
            hdr_beat_q  <= '0;
            pay_cnt_q   <= '0;
            type_q      <= '0;
            id_q        <= '0;
            dtype_q     <= '0;
            n_seg_q     <= '0;
            zero_done_q <= 1'b0;
            run_q       <= 1'b0;
`ifdef SHUNT_HS_SEG_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            seg_idx_q   <= seg_idx_d;
            hdr_beat_q  <= hdr_beat_d;
            pay_cnt_q   <= pay_cnt_d;
            type_q      <= type_d;
            id_q        <= id_d;
            dtype_q     <= dtype_d;
            n_seg_q     <= n_seg_d;
            zero_done_q <= zero_done_d;
            run_q       <= 1'b1;
`ifdef SHUNT_HS_SEG_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    shunt_hs_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .push_sof   (push_sof),
        .push_last  (push_last),
        .push_fin   (push_fin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_last   (out_last),
        .out_fin    (out_fin)
    );

    assign done = (out_valid && out_ready && out_fin) || zero_done_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_shunt_hs_seg_tx.sv
// Directed bench for shunt_hs_seg_tx: framing, multi-segment, backpressure, clamping,
// zero-segment, mid-frame reset and (when SHUNT_HS_SEG_CHECKSUM_EN is defined) checksum beats.
module tb_shunt_hs_seg_tx;

    localparam int DATA_W  = 64;
    localparam int MAX_SEG = 8;
    localparam int SIZE_W  = 16;
    localparam int NSEG_W  = $clog2(MAX_SEG + 1);
`ifdef SHUNT_HS_SEG_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      cmd_valid = 1'b0;
    logic                      cmd_ready;
    logic [63:0]               cmd_trnx_type = '0;
    logic [63:0]               cmd_trnx_id = '0;
    logic [63:0]               cmd_data_type = '0;
    logic [NSEG_W-1:0]         cmd_n_seg = '0;
    logic [MAX_SEG*SIZE_W-1:0] cmd_seg_sizes = '0;
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W-1:0]         out_data;
    logic                      out_sof;
    logic                      out_last;
    logic                      done;
    logic                      busy;

    always #5 clk = ~clk;

    shunt_hs_seg_tx #(
        .DATA_W  (DATA_W),
        .MAX_SEG (MAX_SEG),
        .SIZE_W  (SIZE_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_trnx_type (cmd_trnx_type),
        .cmd_trnx_id   (cmd_trnx_id),
        .cmd_data_type (cmd_data_type),
        .cmd_n_seg     (cmd_n_seg),
        .cmd_seg_sizes (cmd_seg_sizes),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_sof       (out_sof),
        .out_last      (out_last),
        .done          (done),
        .busy          (busy)
    );

    typedef struct {
        logic [63:0] data;
        logic        sof;
        logic        last;
        logic        done;
    } beat_t;

    beat_t       obs_q[$];
    beat_t       exp_q[$];
    logic [63:0] pay_q[$];
    logic [63:0] pay_all[$];

    int          n_assert = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          stall_err = 0;
    int          ovf_err = 0;
    logic        in_acc = 1'b0;
    logic        stall_pend = 1'b0;
    logic [63:0] stall_data = '0;
    bit          rand_ready = 1'b0;
    logic [MAX_SEG*SIZE_W-1:0] sz;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Payload source and downstream ready, updated just after each rising edge.
    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (in_acc && pay_q.size() > 0) void'(pay_q.pop_front());
            in_valid  = (pay_q.size() > 0);
            in_data   = (pay_q.size() > 0) ? pay_q[0] : '0;
            out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Output monitor sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                in_acc     = 1'b0;
                stall_pend = 1'b0;
            end else begin
                beat_t b;
                in_acc = in_valid && in_ready;
                if (out_valid && out_ready) begin
                    b.data = out_data; b.sof = out_sof; b.last = out_last; b.done = done;
                    obs_q.push_back(b);
                end
                if (done) done_cnt++;
                if (stall_pend && (!out_valid || out_data !== stall_data)) stall_err++;
                if (in_ready && out_valid && !out_ready) ovf_err++;
                stall_pend = out_valid && !out_ready;
                stall_data = out_data;
            end
        end
    end

    function automatic beat_t mk(input logic [63:0] d, input logic s, input logic l);
        beat_t b;
        b.data = d; b.sof = s; b.last = l; b.done = 1'b0;
        return b;
    endfunction

    task automatic build_exp(input logic [63:0] t, input logic [63:0] i, input logic [63:0] d,
                             input int nseg, input logic [MAX_SEG*SIZE_W-1:0] sizes);
        int    p;
        beat_t b;
        p = 0;
        exp_q.delete();
        for (int s = 0; s < nseg; s++) begin
            int          ssz;
            logic [63:0] cs;
            ssz = int'(sizes[s*SIZE_W +: SIZE_W]);
            cs  = '0;
            exp_q.push_back(mk(t, 1'b1, 1'b0));
            exp_q.push_back(mk(i, 1'b0, 1'b0));
            exp_q.push_back(mk(d, 1'b0, 1'b0));
            exp_q.push_back(mk(64'(ssz), 1'b0, (ssz == 0) && !CSUM_EN));
            for (int k = 0; k < ssz; k++) begin
                cs ^= pay_all[p];
                exp_q.push_back(mk(pay_all[p], 1'b0, (k == ssz - 1) && !CSUM_EN));
                p++;
            end
            if (CSUM_EN) exp_q.push_back(mk(cs, 1'b0, 1'b1));
        end
        if (exp_q.size() > 0) begin
            b = exp_q.pop_back();
            b.done = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    task automatic send_cmd(input logic [63:0] t, input logic [63:0] i, input logic [63:0] d,
                            input int n, input logic [MAX_SEG*SIZE_W-1:0] sizes);
        @(posedge clk);
        #1;
        cmd_valid     = 1'b1;
        cmd_trnx_type = t;
        cmd_trnx_id   = i;
        cmd_data_type = d;
        cmd_n_seg     = NSEG_W'(n);
        cmd_seg_sizes = sizes;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        chk("cmd_accept", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        // Scramble the command bus to prove the fields were latched.
        cmd_valid     = 1'b0;
        cmd_trnx_type = '1;
        cmd_trnx_id   = '1;
        cmd_data_type = '1;
        cmd_n_seg     = '1;
        cmd_seg_sizes = '1;
    endtask

    task automatic run_txn(input string name, input logic [63:0] t, input logic [63:0] i,
                           input logic [63:0] d, input int nseg_cmd,
                           input logic [MAX_SEG*SIZE_W-1:0] sizes, input bit rnd);
        int nseg;
        int d0;
        int nsof;
        nseg = (nseg_cmd > MAX_SEG) ? MAX_SEG : nseg_cmd;
        d0   = done_cnt;
        build_exp(t, i, d, nseg, sizes);
        obs_q.delete();
        pay_q      = pay_all;
        rand_ready = rnd;
        send_cmd(t, i, d, nseg_cmd, sizes);
        @(negedge clk);
        chk({name, "_first_valid_sof"}, {62'd0, out_valid, out_sof}, 64'd3);
        chk({name, "_busy"}, 64'(busy), 64'd1);
        for (int c = 0; c < 3000 && obs_q.size() < exp_q.size(); c++) @(negedge clk);
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk({name, "_beat_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        nsof = 0;
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            chk($sformatf("%s_b%0d_data", name, k), obs_q[k].data, exp_q[k].data);
            chk($sformatf("%s_b%0d_sof", name, k), 64'(obs_q[k].sof), 64'(exp_q[k].sof));
            chk($sformatf("%s_b%0d_last", name, k), 64'(obs_q[k].last), 64'(exp_q[k].last));
            chk($sformatf("%s_b%0d_done", name, k), 64'(obs_q[k].done), 64'(exp_q[k].done));
            if (obs_q[k].sof) nsof++;
        end
        chk({name, "_sof_count"}, 64'(nsof), 64'(nseg));
        chk({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
        chk({name, "_idle_ready"}, {62'd0, busy, cmd_ready}, 64'd1);
        $display("txn %s: segments=%0d beats=%0d", name, nseg, obs_q.size());
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_sof_last", {62'd0, out_sof, out_last}, 64'd0);
        chk("rst_done_busy", {62'd0, done, busy}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // Basic single segment
        pay_all = '{64'hA, 64'hB, 64'hC};
        sz = '0; sz[0*SIZE_W +: SIZE_W] = 16'd3;
        run_txn("basic", 64'd1, 64'd5, 64'd2, 1, sz, 1'b0);

        // Multi-segment with an empty middle segment
        pay_all = '{64'h100, 64'h101, 64'h102};
        sz = '0;
        sz[0*SIZE_W +: SIZE_W] = 16'd2;
        sz[1*SIZE_W +: SIZE_W] = 16'd0;
        sz[2*SIZE_W +: SIZE_W] = 16'd1;
        run_txn("multi", 64'h11, 64'h22, 64'h33, 3, sz, 1'b0);

        // Random backpressure, 16 payload beats
        pay_all.delete();
        for (int k = 0; k < 16; k++) pay_all.push_back({$urandom(), $urandom()});
        sz = '0; sz[0*SIZE_W +: SIZE_W] = 16'd16;
        stall_err = 0;
        ovf_err = 0;
        run_txn("bp", 64'hDEAD_0001, 64'hBEEF_0002, 64'hCAFE_0003, 1, sz, 1'b1);
        chk("bp_stall_hold", 64'(stall_err), 64'd0);
        chk("bp_no_overrun", 64'(ovf_err), 64'd0);

        // Zero segments: done one cycle after the handshake, nothing emitted
        obs_q.delete();
        pay_all.delete();
        pay_q.delete();
        send_cmd(64'h77, 64'h78, 64'h79, 0, '0);
        chk("nseg0_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("nseg0_done_pulse", 64'(done), 64'd1);
        chk("nseg0_no_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("nseg0_done_clear", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        chk("nseg0_no_beats", 64'(obs_q.size()), 64'd0);
        $display("txn nseg0: done pulse only");

        // Segment count above MAX_SEG is clamped
        pay_all = '{64'h201, 64'h202, 64'h203, 64'h204};
        sz = '0;
        for (int k = 0; k < MAX_SEG; k++) sz[k*SIZE_W +: SIZE_W] = SIZE_W'(k % 2);
        run_txn("clamp", 64'h31, 64'h32, 64'h33, MAX_SEG + 3, sz, 1'b0);

        // Checksum-relevant payload: sizes {2,0}, data F0,0F
        pay_all = '{64'hF0, 64'h0F};
        sz = '0; sz[0*SIZE_W +: SIZE_W] = 16'd2;
        run_txn("csum", 64'h41, 64'h42, 64'h43, 2, sz, 1'b0);

        // Reset in the middle of the payload
        pay_all = '{64'h501, 64'h502, 64'h503, 64'h504, 64'h505};
        pay_q = pay_all;
        obs_q.delete();
        sz = '0; sz[0*SIZE_W +: SIZE_W] = 16'd5;
        send_cmd(64'hA1, 64'hA2, 64'hA3, 1, sz);
        for (int c = 0; c < 200 && obs_q.size() < 6; c++) @(negedge clk);
        chk("midrst_progress", 64'(obs_q.size() >= 6), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        pay_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        obs_q.delete();
        $display("txn midrst: frame abandoned on reset");

        // Clean frame after reset
        pay_all = '{64'hDEAD};
        sz = '0; sz[0*SIZE_W +: SIZE_W] = 16'd1;
        run_txn("post_rst", 64'd7, 64'd8, 64'd9, 1, sz, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
